// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if -- bundle between the EX stage and the sequential
// multiplier controller.
//   Start  : EX-stage instruction is MUL, held while it sits stalled
//   Flush  : pipeline flush, aborts any operation
//   SrcA   : multiplicand
//   SrcB   : multiplier
//   Stall  : freezes PC, IF/ID, ID/EX and bubbles EX/MEM
//   Busy   : multiplier is iterating
//   Done   : one-cycle pulse, Result valid
//   Result : low WIDTH bits of SrcA*SrcB
// master = pipeline side, slave = multiplier side.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Flush;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  modport master (
    output Start, Flush, SrcA, SrcB,
    input  Stall, Busy, Done, Result
  );

  modport slave (
    input  Start, Flush, SrcA, SrcB,
    output Stall, Busy, Done, Result
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- shift-and-add multiplier that stalls the pipeline while a
// MUL instruction is in EX. Produces the low WIDTH bits of SrcA*SrcB, which
// are identical for signed and unsigned operands.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : mul_seq_ctrl_if.slave (Start/Flush/SrcA/SrcB in,
//          Stall/Busy/Done/Result out)
// Build option:
//   MUL_EARLY_EXIT_EN : when defined, RUN ends as soon as the remaining
//                       multiplier bits are all zero (result unchanged).
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mul_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] result_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] acc_sum_s;
  logic             accept_s;
  logic             last_s;

  // Accumulator value after the current RUN step.
  always_comb begin
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  // A new MUL is taken only from IDLE, and Flush wins over Start.
  always_comb begin
    accept_s = (state_r == IDLE) && bus.Start && !bus.Flush;
  end

  // Final RUN step detection.
`ifdef MUL_EARLY_EXIT_EN
  always_comb begin
    last_s = ((mplier_r >> 1) == {WIDTH{1'b0}}) || (count_r == LAST_CNT);
  end
`else
  always_comb begin
    last_s = (count_r == LAST_CNT);
  end
`endif

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.Flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Start) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Operand load, shift-and-add iteration and result capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r  <= bus.SrcA;
            mplier_r <= bus.SrcB;
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
          // Capture on entry to DONE so Result is valid together with Done.
          // A flush on this edge leaves the previous Result intact.
          if (last_s && !bus.Flush) begin
            result_r <= acc_sum_s;
          end
        end
        DONE: begin
          result_r <= acc_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  // FSM outputs. Stall includes the accept cycle so the MUL holds in EX
  // from the cycle it is first seen; RST gating keeps Stall low in reset
  // even while Start is high.
  always_comb begin
    bus.Stall  = RST && (accept_s || (state_r == RUN));
    bus.Busy   = (state_r == RUN);
    bus.Done   = (state_r == DONE) && !bus.Flush;
    bus.Result = result_r;
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl -- self-checking bench for mul_seq_ctrl (WIDTH=32).
// Expected products come from plain 32-bit multiplication; expected RUN
// length comes from the multiplier's most significant set bit when
// MUL_EARLY_EXIT_EN is defined, otherwise 32.
module tb_mul_seq_ctrl;

  logic CLK;
  logic RST;
  int   total;
  int   bad;
  logic [31:0] model_result;

  mul_seq_ctrl_if #(.WIDTH(32)) bus ();

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_runs(input logic [31:0] b);
    int msb;
`ifdef MUL_EARLY_EXIT_EN
    msb = -1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) msb = i;
    end
    ref_runs = (msb < 0) ? 1 : msb + 1;
`else
    msb = 31;
    ref_runs = msb + 1;
`endif
  endfunction

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  // Full MUL: cycle 0 accept, RUN cycles 1..runs, Done at runs+1.
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input bit start_in_done);
    logic [31:0] exp_p;
    logic [31:0] exp_r;
    int runs;
    exp_p = a * b;
    runs  = ref_runs(b);
    bus.Start = 1'b1;
    bus.Flush = 1'b0;
    bus.SrcA  = a;
    bus.SrcB  = b;
    for (int c = 0; c <= runs + 1; c++) begin
      @(negedge CLK);
      exp_r = (c == runs + 1) ? exp_p : model_result;
      total++;
      if (bus.Stall !== (c <= runs)) begin
        bad++;
        $display("FAIL %s stall c=%0d got %b want %b", tag, c, bus.Stall, (c <= runs));
      end
      total++;
      if (bus.Busy !== (c >= 1 && c <= runs)) begin
        bad++;
        $display("FAIL %s busy c=%0d got %b want %b", tag, c, bus.Busy, (c >= 1 && c <= runs));
      end
      total++;
      if (bus.Done !== (c == runs + 1)) begin
        bad++;
        $display("FAIL %s done c=%0d got %b want %b", tag, c, bus.Done, (c == runs + 1));
      end
      total++;
      if (bus.Result !== exp_r) begin
        bad++;
        $display("FAIL %s result c=%0d got %h want %h", tag, c, bus.Result, exp_r);
      end
      next_cycle();
      if (c == runs) bus.Start = start_in_done;
    end
    model_result = exp_p;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    bus.Start = 1'b1;
    bus.Flush = 1'b0;
    bus.SrcA  = 32'd3;
    bus.SrcB  = 32'd4;
    model_result = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000 || bus.Result !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got stall=%b busy=%b done=%b result=%h want 0 0 0 0",
               bus.Stall, bus.Busy, bus.Done, bus.Result);
    end
    next_cycle();
    bus.Start = 1'b0;
    RST = 1'b1;
    next_cycle();
  endtask

  task automatic test_basic;
    run_op("mul_7x6", 32'd7, 32'd6, 1'b0);
  endtask

  task automatic test_corners;
    run_op("ones_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("msb_x2", 32'h8000_0000, 32'd2, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op("rand", a, b, 1'b0);
    end
  endtask

  task automatic test_flush;
    logic [31:0] a;
    logic [31:0] b;
    run_op("pre_flush", 32'd7, 32'd6, 1'b0);
    a = $urandom;
    b = $urandom | 32'h8000_0000;
    bus.Start = 1'b1;
    bus.SrcA  = a;
    bus.SrcB  = b;
    repeat (10) next_cycle();
    // RUN cycle 10: a new MUL reaches EX together with a flush.
    bus.Flush = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle got busy=%b done=%b want 1 0", bus.Busy, bus.Done);
    end
    next_cycle();
    bus.Flush = 1'b0;
    bus.Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      total++;
      if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000 || bus.Result !== 32'd42) begin
        bad++;
        $display("FAIL after_flush k=%0d got stall=%b busy=%b done=%b result=%h want 0 0 0 0000002a",
                 k, bus.Stall, bus.Busy, bus.Done, bus.Result);
      end
      next_cycle();
    end
    // Start and Flush together in IDLE: flush wins, nothing starts.
    bus.Start = 1'b1;
    bus.Flush = 1'b1;
    @(negedge CLK);
    total++;
    if (bus.Stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_prio_stall got %b want 0", bus.Stall);
    end
    next_cycle();
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_prio_busy got %b want 0", bus.Busy);
    end
    next_cycle();
  endtask

  task automatic test_async_reset;
    bus.Start = 1'b1;
    bus.Flush = 1'b0;
    bus.SrcA  = $urandom;
    bus.SrcB  = $urandom | 32'h8000_0000;
    repeat (6) next_cycle();
    #2;
    RST = 1'b0;
    #1;
    model_result = 32'd0;
    total++;
    if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000 || bus.Result !== 32'd0) begin
      bad++;
      $display("FAIL async_reset got stall=%b busy=%b done=%b result=%h want 0 0 0 0",
               bus.Stall, bus.Busy, bus.Done, bus.Result);
    end
    next_cycle();
    total++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got busy=%b done=%b want 0 0", bus.Busy, bus.Done);
    end
    RST = 1'b1;
    run_op("post_reset", $urandom, $urandom, 1'b0);
  endtask

  task automatic test_early_exit;
    run_op("ee_5x3", 32'd5, 32'd3, 1'b0);
    run_op("ee_bzero", $urandom, 32'd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_first", $urandom, $urandom, 1'b1);
    run_op("b2b_9x9", 32'd9, 32'd9, 1'b0);
    total++;
    if (model_result !== 32'd81 || bus.Result !== 32'd81) begin
      bad++;
      $display("FAIL b2b_result got %h want 00000051", bus.Result);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    bus.SrcA  = 32'd0;
    bus.SrcB  = 32'd0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_flush();
    test_async_reset();
    test_early_exit();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
